// File: rtl/branch_sequencer.sv
// Branch/jump sequencer for the Harvard MIPS core.
// Owns the FETCH/EXEC phase and the delay-slot target hold.
module branch_sequencer #(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG  = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction_word,
  input  logic [31:0] pc_current,
  input  logic [31:0] read_data_0,
  input  logic        N,
  input  logic        Z,
  output logic        state,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        link_en,
  output logic [4:0]  link_reg,
  output logic [31:0] link_addr,
  output logic        finish
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_t;

  phase_t      st_q, st_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic        phalt_q, phalt_d;
  logic        halted_q, halted_d;

  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign opcode = instruction_word[31:26];
  assign rt     = instruction_word[20:16];
  assign funct  = instruction_word[5:0];
  assign imm    = instruction_word[15:0];
  assign pc4    = pc_current + 32'd4;
  assign br_tgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_tgt  = {pc4[31:28], instruction_word[25:0], 2'b00};

  logic is_j, is_jal, is_beq, is_bne;
  logic is_blez, is_bgtz, is_jr, is_jalr;
  logic is_bltz, is_bgez, is_bltzal, is_bgezal;

  assign is_j      = opcode == 6'd2;
  assign is_jal    = opcode == 6'd3;
  assign is_beq    = opcode == 6'd4;
  assign is_bne    = opcode == 6'd5;
  assign is_blez   = opcode == 6'd6;
  assign is_bgtz   = opcode == 6'd7;
  assign is_jr     = opcode == 6'd0 && funct == 6'd8;
  assign is_jalr   = opcode == 6'd0 && funct == 6'd9;
  assign is_bltz   = opcode == 6'd1 && rt == 5'd0;
  assign is_bgez   = opcode == 6'd1 && rt == 5'd1;
  assign is_bltzal = opcode == 6'd1 && rt == 5'd16;
  assign is_bgezal = opcode == 6'd1 && rt == 5'd17;

  logic        cti;
  logic        taken;
  logic        link;
  logic [31:0] target;

  always_comb begin
    cti    = 1'b0;
    taken  = 1'b0;
    link   = 1'b0;
    target = br_tgt;
    unique case (1'b1)
      is_j: begin
        cti    = 1'b1;
        taken  = 1'b1;
        target = j_tgt;
      end
      is_jal: begin
        cti    = 1'b1;
        taken  = 1'b1;
        link   = 1'b1;
        target = j_tgt;
      end
      is_beq: begin
        cti   = 1'b1;
        taken = Z;
      end
      is_bne: begin
        cti   = 1'b1;
        taken = !Z;
      end
      is_blez: begin
        cti   = 1'b1;
        taken = N | Z;
      end
      is_bgtz: begin
        cti   = 1'b1;
        taken = !N && !Z;
      end
      is_bltz, is_bltzal: begin
        cti   = 1'b1;
        taken = N;
        link  = is_bltzal;
      end
      is_bgez, is_bgezal: begin
        cti   = 1'b1;
        taken = !N;
        link  = is_bgezal;
      end
      is_jr, is_jalr: begin
        cti    = 1'b1;
        taken  = 1'b1;
        link   = is_jalr;
        target = read_data_0;
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    phalt_d  = phalt_q;
    halted_d = halted_q;
    pc_en    = 1'b0;
    pc_next  = 32'd0;
    link_en  = 1'b0;
    if (st_q == EXEC && !halted_q)
      pc_next = pend_q ? tgt_q : pc4;
    if (!stall) begin
      if (halted_q) begin
        st_d = FETCH;
      end else if (st_q == FETCH) begin
        st_d = EXEC;
      end else begin
        st_d    = FETCH;
        pc_en   = 1'b1;
        link_en = link;
        // Delay slot: apply held target; any branch here is ignored
        if (pend_q) begin
          pend_d = 1'b0;
          if (phalt_q) begin
            halted_d = 1'b1;
            phalt_d  = 1'b0;
          end
        end else if (cti && taken) begin
          pend_d  = 1'b1;
          tgt_d   = target;
          phalt_d = (is_jr || is_jalr) &&
                    read_data_0 == HALT_ADDR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= FETCH;
      pend_q   <= 1'b0;
      tgt_q    <= 32'd0;
      phalt_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      phalt_q  <= phalt_d;
      halted_q <= halted_d;
    end
  end

  assign state     = st_q;
  assign finish    = halted_q;
  assign link_reg  = is_jalr ? instruction_word[15:11] : LINK_REG;
  assign link_addr = pc_current + 32'd8;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer.
// Expected outputs are queued at drive time and checked mid-cycle.
module tb_branch_sequencer;

  localparam logic [31:0] NOP = 32'h0060_000B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] iw = '0;
  logic [31:0] pc = '0;
  logic [31:0] rd0 = '0;
  logic        n = 1'b0;
  logic        z = 1'b0;
  logic        state;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        link_en;
  logic [4:0]  link_reg;
  logic [31:0] link_addr;
  logic        finish;

  branch_sequencer dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .instruction_word(iw),
    .pc_current(pc),
    .read_data_0(rd0),
    .N(n),
    .Z(z),
    .state(state),
    .pc_en(pc_en),
    .pc_next(pc_next),
    .link_en(link_en),
    .link_reg(link_reg),
    .link_addr(link_addr),
    .finish(finish)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        en;
    logic        chk_pc;
    logic [31:0] nxt;
    logic        lnk;
    logic [4:0]  lreg;
    logic [31:0] laddr;
    logic        fin;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t got=%h exp=%h",
               tag, $time, got, exp);
    end
  endtask

  function automatic exp_t fe(input logic f);
    exp_t e;
    e = '0;
    e.fin = f;
    return e;
  endfunction

  function automatic exp_t rs_e();
    exp_t e;
    e = '0;
    e.chk_pc = 1'b1;
    return e;
  endfunction

  function automatic exp_t ex(input logic [31:0] nx);
    exp_t e;
    e = '0;
    e.st = 1'b1;
    e.en = 1'b1;
    e.chk_pc = 1'b1;
    e.nxt = nx;
    return e;
  endfunction

  function automatic exp_t exl(input logic [31:0] nx,
                               input logic [4:0] lr);
    exp_t e;
    e = ex(nx);
    e.lnk = 1'b1;
    e.lreg = lr;
    return e;
  endfunction

  function automatic exp_t stl();
    exp_t e;
    e = '0;
    e.st = 1'b1;
    return e;
  endfunction

  task automatic step(input logic r,
                      input logic [31:0] i,
                      input logic [31:0] p,
                      input logic [31:0] d,
                      input logic nn,
                      input logic zz,
                      input logic s,
                      input exp_t e);
    exp_t x;
    @(negedge clk);
    reset = r;
    iw = i;
    pc = p;
    rd0 = d;
    n = nn;
    z = zz;
    stall = s;
    e.laddr = p + 32'd8;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    chk("state", 32'(state), 32'(x.st));
    chk("pc_en", 32'(pc_en), 32'(x.en));
    if (x.chk_pc)
      chk("pc_next", pc_next, x.nxt);
    chk("link_en", 32'(link_en), 32'(x.lnk));
    if (x.lnk)
      chk("link_reg", 32'(link_reg), 32'(x.lreg));
    chk("link_addr", link_addr, x.laddr);
    chk("finish", 32'(finish), 32'(x.fin));
  endtask

  task automatic instr(input logic [31:0] i,
                       input logic [31:0] p,
                       input logic [31:0] d,
                       input logic nn,
                       input logic zz,
                       input exp_t e);
    step(1'b1, i, p, d, nn, zz, 1'b0, fe(1'b0));
    step(1'b1, i, p, d, nn, zz, 1'b0, e);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2)
      step(1'b0, NOP, 32'hBFC0_0000, 0, 0, 0, 0, rs_e());

    // plain ALU op, two instruction cycles
    repeat (2)
      instr(NOP, 32'hBFC0_0000, 0, 0, 0, ex(32'hBFC0_0004));

    // BLTZ taken then not taken
    instr(32'h0400_0002, 32'hBFC0_0004, 0, 1, 0,
          ex(32'hBFC0_0008));
    instr(NOP, 32'hBFC0_0008, 0, 0, 0, ex(32'hBFC0_0010));
    instr(32'h0400_0002, 32'hBFC0_0004, 0, 0, 0,
          ex(32'hBFC0_0008));
    instr(NOP, 32'hBFC0_0008, 0, 0, 0, ex(32'hBFC0_000C));

    // JAL with link
    instr(32'h0C00_0040, 32'hBFC0_0020, 0, 0, 0,
          exl(32'hBFC0_0024, 5'd31));
    instr(NOP, 32'hBFC0_0024, 0, 0, 0, ex(32'hB000_0100));

    // BGEZAL not taken still links
    instr(32'h0411_0008, 32'hBFC0_0200, 0, 1, 0,
          exl(32'hBFC0_0204, 5'd31));
    instr(NOP, 32'hBFC0_0204, 0, 0, 0, ex(32'hBFC0_0208));

    // JALR rd=7 to non-halt address
    instr(32'h0000_3809, 32'hBFC0_0300, 32'h0040_0000, 0, 0,
          exl(32'hBFC0_0304, 5'd7));
    instr(NOP, 32'hBFC0_0304, 0, 0, 0, ex(32'h0040_0000));
    instr(NOP, 32'h0040_0000, 0, 0, 0, ex(32'h0040_0004));

    // BGTZ whose target wraps to zero: no halt
    instr(32'h1C00_0001, 32'hFFFF_FFF8, 0, 0, 0,
          ex(32'hFFFF_FFFC));
    instr(NOP, 32'hFFFF_FFFC, 0, 0, 0, ex(32'h0000_0000));
    instr(NOP, 32'h0000_0000, 0, 0, 0, ex(32'h0000_0004));

    // JR to HALT_ADDR
    instr(32'h0000_0008, 32'hBFC0_0030, 0, 0, 0,
          ex(32'hBFC0_0034));
    instr(NOP, 32'hBFC0_0034, 0, 0, 0, ex(32'h0000_0000));
    repeat (12)
      step(1'b1, 32'h0C00_0040, 0, 0, 0, 0, 0, fe(1'b1));
    repeat (2)
      step(1'b0, NOP, 0, 0, 0, 0, 0, rs_e());

    // BEQ taken, stall in fetch and in delay-slot exec
    instr(32'h1000_0010, 32'hBFC0_0040, 0, 0, 1,
          ex(32'hBFC0_0044));
    step(1'b1, NOP, 32'hBFC0_0044, 0, 0, 0, 1, fe(1'b0));
    step(1'b1, NOP, 32'hBFC0_0044, 0, 0, 0, 0, fe(1'b0));
    repeat (3)
      step(1'b1, NOP, 32'hBFC0_0044, 0, 0, 0, 1, stl());
    step(1'b1, NOP, 32'hBFC0_0044, 0, 0, 0, 0,
         ex(32'hBFC0_0084));
    instr(NOP, 32'hBFC0_0084, 0, 0, 0, ex(32'hBFC0_0088));

    // J in delay slot of taken BEQ is ignored
    instr(32'h1000_0004, 32'hBFC0_0100, 0, 0, 1,
          ex(32'hBFC0_0104));
    instr(32'h0800_0123, 32'hBFC0_0104, 0, 0, 0,
          ex(32'hBFC0_0114));
    instr(NOP, 32'hBFC0_0114, 0, 0, 0, ex(32'hBFC0_0118));

    // reset during delay slot drops the pending target
    instr(32'h1000_0004, 32'hBFC0_0400, 0, 0, 1,
          ex(32'hBFC0_0404));
    repeat (2)
      step(1'b0, NOP, 32'hBFC0_0404, 0, 0, 0, 0, rs_e());
    instr(NOP, 32'hBFC0_0404, 0, 0, 0, ex(32'hBFC0_0408));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
